// File: rtl/ram_port_arbiter_pkg.sv
// Shared constants and enumerations for the two-port RAM arbiter.
package ram_port_arbiter_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  // Top-level operating mode: normal arbitration or zero-fill sweep.
  typedef enum logic {
    ARB  = 1'b0,
    INIT = 1'b1
  } state_t;

  // Names a requester; used for the round-robin pointer and the read tag.
  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant, registered pointer.
module rr_arbiter2
  import ram_port_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  owner_t ptr;

  // Grant the sole requester, or the pointer's choice when both ask.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (enable) begin
      if (req_a && req_b) begin
        gnt_a = (ptr == OWN_A);
        gnt_b = (ptr == OWN_B);
      end else begin
        gnt_a = req_a;
        gnt_b = req_b;
      end
    end
  end

  // After any grant the pointer favours the other requester next time.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      ptr <= OWN_A;
    end else if (gnt_a) begin
      ptr <= OWN_B;
    end else if (gnt_b) begin
      ptr <= OWN_A;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port synchronous RAM between requesters A and B and
// runs a zero-fill sweep on request. Drives every RAM port.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              init_start,
  output logic              init_busy,
  input  logic              req_a,
  input  logic              wr_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] din_a,
  output logic              gnt_a,
  output logic              rvalid_a,
  output logic [DATA_W-1:0] dout_a,
  input  logic              req_b,
  input  logic              wr_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] din_b,
  output logic              gnt_b,
  output logic              rvalid_b,
  output logic [DATA_W-1:0] dout_b,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q;
  logic [ADDR_W-1:0]   last_addr_q;
  logic                rd_valid_q;
  owner_t              rd_owner_q;
  logic [DATA_W-1:0]   hold_a_q, hold_b_q;
  logic                sweep_last;

  assign sweep_last = (cnt_q == ADDR_W'(DEPTH - 1));

  rr_arbiter2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .enable (state_q == ARB),
    .req_a  (req_a),
    .req_b  (req_b),
    .gnt_a  (gnt_a),
    .gnt_b  (gnt_b)
  );

  // Next state and RAM port mux; the address holds when nothing is granted.
  always_comb begin
    state_d   = state_q;
    init_busy = 1'b0;
    ram_write = 1'b0;
    ram_addr  = last_addr_q;
    ram_din   = '0;
    case (state_q)
      ARB: begin
        if (gnt_a) begin
          ram_write = wr_a;
          ram_addr  = addr_a;
          ram_din   = din_a;
        end else if (gnt_b) begin
          ram_write = wr_b;
          ram_addr  = addr_b;
          ram_din   = din_b;
        end
        if (init_start) state_d = INIT;
      end
      INIT: begin
        init_busy = 1'b1;
        ram_write = 1'b1;
        ram_addr  = cnt_q;
        ram_din   = '0;
        if (sweep_last) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ARB;
    else       state_q <= state_d;
  end

  // Sweep counter steps once per INIT cycle and returns to zero after the last location.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state_q == INIT) begin
      cnt_q <= sweep_last ? '0 : cnt_q + 1'b1;
    end
  end

  // Remember the last address actually driven so idle cycles hold it.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_addr_q <= '0;
    end else if (gnt_a || gnt_b || (state_q == INIT)) begin
      last_addr_q <= ram_addr;
    end
  end

  // Tag each granted read with its owner; data returns on the next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_owner_q <= OWN_A;
    end else begin
      rd_valid_q <= (gnt_a && !wr_a) || (gnt_b && !wr_b);
      rd_owner_q <= gnt_b ? OWN_B : OWN_A;
    end
  end

  assign rvalid_a = rd_valid_q && (rd_owner_q == OWN_A);
  assign rvalid_b = rd_valid_q && (rd_owner_q == OWN_B);

  // Capture returned data so each requester's dout holds between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_a_q <= '0;
      hold_b_q <= '0;
    end else begin
      if (rvalid_a) hold_a_q <= ram_dout;
      if (rvalid_b) hold_b_q <= ram_dout;
    end
  end

  assign dout_a = rvalid_a ? ram_dout : hold_a_q;
  assign dout_b = rvalid_b ? ram_dout : hold_b_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural RAM and a
// cycle-level reference model compared on every falling edge.
module tb_ram_port_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       init_start = 1'b0;
  logic       init_busy;
  logic       req_a = 1'b0, wr_a = 1'b0, req_b = 1'b0, wr_b = 1'b0;
  logic [4:0] addr_a = '0, addr_b = '0;
  logic [3:0] din_a = '0, din_b = '0;
  logic       gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [3:0] dout_a, dout_b;
  logic       ram_write;
  logic [4:0] ram_addr;
  logic [3:0] ram_din;
  logic [3:0] ram_dout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_port_arbiter dut (
    .clk(clk), .reset(reset), .init_start(init_start), .init_busy(init_busy),
    .req_a(req_a), .wr_a(wr_a), .addr_a(addr_a), .din_a(din_a),
    .gnt_a(gnt_a), .rvalid_a(rvalid_a), .dout_a(dout_a),
    .req_b(req_b), .wr_b(wr_b), .addr_b(addr_b), .din_b(din_b),
    .gnt_b(gnt_b), .rvalid_b(rvalid_b), .dout_b(dout_b),
    .ram_write(ram_write), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  // Behavioural 32x4 synchronous RAM, cleared once at start-up.
  logic       boot = 1'b1;
  logic [3:0] mem [32];
  always @(posedge clk) begin
    if (boot) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else begin
      if (ram_write) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [3:0] sh [32];
  logic       m_live = 0, m_init = 0, m_ptr_b = 0, m_pv = 0, m_pown_b = 0;
  logic [4:0] m_cnt = '0, m_last = '0;
  logic [3:0] m_pdata = '0, m_hold_a = '0, m_hold_b = '0;
  logic       e_ga, e_gb, e_wr, e_busy, e_rva, e_rvb, e_rd;
  logic [4:0] e_addr;
  logic [3:0] e_din, e_da, e_db;

  always @(negedge clk) begin
    if (m_init) begin
      e_ga = 0; e_gb = 0; e_wr = 1; e_addr = m_cnt; e_din = 0; e_busy = 1;
    end else begin
      e_busy = 0;
      if (req_a && req_b) begin
        e_ga = !m_ptr_b; e_gb = m_ptr_b;
      end else begin
        e_ga = req_a; e_gb = req_b;
      end
      if (e_ga)      begin e_wr = wr_a; e_addr = addr_a; e_din = din_a; end
      else if (e_gb) begin e_wr = wr_b; e_addr = addr_b; e_din = din_b; end
      else           begin e_wr = 0;    e_addr = m_last; e_din = 0;     end
    end
    e_rd  = (e_ga && !wr_a) || (e_gb && !wr_b);
    e_rva = m_pv && !m_pown_b;
    e_rvb = m_pv && m_pown_b;
    e_da  = e_rva ? m_pdata : m_hold_a;
    e_db  = e_rvb ? m_pdata : m_hold_b;

    if (m_live) begin
      check("gnt_a", gnt_a, e_ga);
      check("gnt_b", gnt_b, e_gb);
      check("init_busy", init_busy, e_busy);
      check("ram_write", ram_write, e_wr);
      check("ram_addr", ram_addr, e_addr);
      if (e_ga || e_gb || m_init) check("ram_din", ram_din, e_din);
      check("rvalid_a", rvalid_a, e_rva);
      check("rvalid_b", rvalid_b, e_rvb);
      check("dout_a", dout_a, e_da);
      check("dout_b", dout_b, e_db);
      if (e_wr) sh[e_addr] = e_din;
    end

    if (reset) begin
      if (!m_live) for (int i = 0; i < 32; i++) sh[i] = '0;
      m_live = 1; m_init = 0; m_cnt = '0; m_ptr_b = 0; m_last = '0;
      m_pv = 0; m_pown_b = 0; m_hold_a = '0; m_hold_b = '0;
    end else begin
      m_hold_a = e_da;
      m_hold_b = e_db;
      m_pv     = e_rd;
      m_pown_b = e_gb;
      m_pdata  = sh[e_addr];
      if (e_ga || e_gb || m_init) m_last = e_addr;
      if (e_ga) m_ptr_b = 1;
      else if (e_gb) m_ptr_b = 0;
      if (m_init) begin
        if (m_cnt == 5'd31) begin m_init = 0; m_cnt = '0; end
        else m_cnt = m_cnt + 5'd1;
      end else if (init_start) begin
        m_init = 1; m_cnt = '0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input logic r, input logic w, input logic [4:0] a, input logic [3:0] d);
    req_a = r; wr_a = w; addr_a = a; din_a = d;
  endtask

  task automatic drv_b(input logic r, input logic w, input logic [4:0] a, input logic [3:0] d);
    req_b = r; wr_b = w; addr_b = a; din_b = d;
  endtask

  task automatic idle();
    drv_a(0, 0, '0, '0);
    drv_b(0, 0, '0, '0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Read one address through A and check the returned value.
  task automatic read_a_expect(input logic [4:0] a, input logic [3:0] exp, input string name);
    drv_a(1, 0, a, '0);
    tick();
    idle();
    @(negedge clk);
    check({name, "_rvalid"}, rvalid_a, 1'b1);
    check(name, dout_a, exp);
    tick();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  logic [4:0] rd_list [3];
  int         busy_cnt;
  int         idx;
  logic       seq_ok;
  logic       b_leak;

  initial begin
    rd_list = '{5'd0, 5'd17, 5'd31};
    idle();
    tick();
    boot = 1'b0;
    tick();
    reset = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_busy", init_busy, 1'b0);
    check("rst_ram_addr", ram_addr, 5'd0);
    check("rst_dout_a", dout_a, 4'h0);
    tick();

    // 1: write then read same address.
    drv_a(1, 1, 5'd5, 4'hA);
    @(negedge clk);
    check("t1_gnt_wr", gnt_a, 1'b1);
    tick();
    drv_a(1, 0, 5'd5, 4'h0);
    @(negedge clk);
    check("t1_gnt_rd", gnt_a, 1'b1);
    tick();
    idle();
    @(negedge clk);
    check("t1_rvalid", rvalid_a, 1'b1);
    check("t1_dout", dout_a, 4'hA);
    tick();

    // 2: both requesting, alternating grants from pointer = A.
    do_reset();
    drv_a(1, 1, 5'd10, 4'h3);
    drv_b(1, 1, 5'd11, 4'h4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t2_gnt_a", gnt_a, (i % 2) == 0);
      check("t2_gnt_b", gnt_b, (i % 2) == 1);
      check("t2_addr", ram_addr, (i % 2) ? 5'd11 : 5'd10);
      tick();
    end
    idle();

    // 3: back-to-back reads by A then B.
    drv_a(1, 1, 5'd3, 4'h3);
    tick();
    idle();
    drv_b(1, 1, 5'd7, 4'h7);
    tick();
    idle();
    drv_a(1, 0, 5'd3, 4'h0);
    tick();
    idle();
    drv_b(1, 0, 5'd7, 4'h0);
    @(negedge clk);
    check("t3_rvalid_a", rvalid_a, 1'b1);
    check("t3_dout_a", dout_a, 4'h3);
    check("t3_rvalid_b_early", rvalid_b, 1'b0);
    tick();
    idle();
    @(negedge clk);
    check("t3_rvalid_b", rvalid_b, 1'b1);
    check("t3_dout_b", dout_b, 4'h7);
    check("t3_rvalid_a_late", rvalid_a, 1'b0);
    tick();

    // 4: fill with 0xF, then sweep clears everything.
    for (int i = 0; i < 32; i++) begin
      drv_a(1, 1, 5'(i), 4'hF);
      tick();
    end
    idle();
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    busy_cnt = 0;
    idx = 0;
    seq_ok = 1'b1;
    for (int c = 0; c < 34; c++) begin
      @(negedge clk);
      if (init_busy) begin
        busy_cnt++;
        if (ram_addr != 5'(idx) || ram_write !== 1'b1 || ram_din != 4'h0) seq_ok = 1'b0;
        idx++;
      end
      tick();
    end
    check("t4_busy_cycles", busy_cnt, 32);
    check("t4_sweep_seq", seq_ok, 1'b1);
    for (int k = 0; k < 3; k++) read_a_expect(rd_list[k], 4'h0, "t4_cleared");

    // 5: init_start coincides with an A read; B waits out the sweep.
    drv_a(1, 1, 5'd2, 4'h5);
    tick();
    drv_a(1, 0, 5'd2, 4'h0);
    init_start = 1'b1;
    @(negedge clk);
    check("t5_gnt_a", gnt_a, 1'b1);
    tick();
    init_start = 1'b0;
    drv_a(0, 0, '0, '0);
    drv_b(1, 0, 5'd7, 4'h0);
    @(negedge clk);
    check("t5_rvalid_a", rvalid_a, 1'b1);
    check("t5_dout_a", dout_a, 4'h5);
    check("t5_busy", init_busy, 1'b1);
    tick();
    b_leak = 1'b0;
    for (int c = 0; c < 31; c++) begin
      @(negedge clk);
      if (gnt_b !== 1'b0) b_leak = 1'b1;
      tick();
    end
    check("t5_no_gnt_b_in_init", b_leak, 1'b0);
    @(negedge clk);
    check("t5_gnt_b_after", gnt_b, 1'b1);
    check("t5_busy_after", init_busy, 1'b0);
    tick();
    idle();
    @(negedge clk);
    check("t5_rvalid_b", rvalid_b, 1'b1);
    check("t5_dout_b", dout_b, 4'h0);
    tick();

    // 6: reset in the middle of a sweep.
    drv_a(1, 1, 5'd20, 4'h9);
    tick();
    idle();
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    @(negedge clk);
    check("t6_count10", ram_addr, 5'd10);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("t6_busy", init_busy, 1'b0);
    check("t6_gnt_a", gnt_a, 1'b0);
    check("t6_gnt_b", gnt_b, 1'b0);
    check("t6_rvalid_a", rvalid_a, 1'b0);
    check("t6_rvalid_b", rvalid_b, 1'b0);
    check("t6_ram_write", ram_write, 1'b0);
    check("t6_ram_addr", ram_addr, 5'd0);
    check("t6_dout_a", dout_a, 4'h0);
    check("t6_dout_b", dout_b, 4'h0);
    tick();
    for (int i = 0; i < 10; i++) read_a_expect(5'(i), 4'h0, "t6_cleared");
    read_a_expect(5'd20, 4'h9, "t6_kept");

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one 32x4 single-port synchronous RAM between two requesters, A and B, using round-robin arbitration with one access per cycle.
- Also runs an init sweep that clears every location to zero.
- Sits between the switch/key-cleaning front end and the RAM instance, and drives all RAM ports.
- Returns read data to the requester that issued the read, with a valid strobe.

Parameters:
ADDR_W, 5, RAM address width
DATA_W, 4, RAM data width
DEPTH, 32, number of locations swept by init (2**ADDR_W)

Ports:
clk  in  1  single system clock
reset  in  1  synchronous, active-high reset
init_start  in  1  pulse or level; requests a zero-fill sweep
init_busy  out  1  high while the sweep runs
req_a  in  1  requester A wants an access this cycle
wr_a  in  1  A access is a write (1) or read (0)
addr_a  in  ADDR_W  A address
din_a  in  DATA_W  A write data
gnt_a  out  1  A access accepted this cycle
rvalid_a  out  1  read data for A valid this cycle
dout_a  out  DATA_W  read data to A
req_b, wr_b, addr_b, din_b, gnt_b, rvalid_b, dout_b  same as A, for requester B
ram_write  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_din  out  DATA_W  RAM write data
ram_dout  in  DATA_W  RAM read data, valid one cycle after the address is sampled

Behaviour:
- The clock is clk; reset is synchronous and active-high. All state changes occur on the rising edge of clk.
- Reset values:
  - state = ARB; priority pointer = A; sweep counter = 0.
  - init_busy = 0, gnt_a = gnt_b = 0, rvalid_a = rvalid_b = 0.
  - ram_write = 0, ram_addr = 0, ram_din = 0, dout_a = dout_b = 0.
- FSM states: ARB, INIT.
- ARB, grant rule (combinational, same cycle as req):
  - Only one requester active: grant it.
  - Both active: grant the requester named by the pointer.
  - Neither active: no grant; ram_write = 0; ram_addr holds its last value.
- ARB, pointer update: after any grant, the pointer moves to the other requester.
- ARB, RAM drive: ram_write, ram_addr and ram_din come from the granted requester's wr/addr/din.
- Ungranted requester: must hold req and its fields stable until granted; no internal queueing.
- Read return:
  - A granted read (wr = 0) sets the matching rvalid exactly one cycle later, via a registered owner tag.
  - dout_x = ram_dout while rvalid_x is high; dout_x holds its last value otherwise.
  - Write latency is 0: a read of the same address on the next cycle returns the new data.
- Back-to-back: A read at cycle n, then B read at n+1, gives rvalid_a at n+1 and rvalid_b at n+2. Throughput is 1 access per cycle.
- ARB -> INIT: taken on any edge where init_start = 1. A request granted in that same cycle still completes, and its rvalid is delivered during the first INIT cycle.
- INIT:
  - gnt_a = gnt_b = 0; requests are ignored and not lost.
  - init_busy = 1.
  - ram_write = 1, ram_din = 0, ram_addr = sweep counter.
  - The counter increments 0..DEPTH-1, one per cycle, so the sweep lasts exactly DEPTH cycles.
  - init_start is ignored while in INIT.
- INIT -> ARB: after the write of address DEPTH-1. The counter returns to 0, with no wrap beyond DEPTH-1. The pointer is unchanged by INIT.
- Reset mid-INIT: return to ARB immediately on the next edge. RAM contents are then partially cleared, which is acceptable.
- Reset also clears any pending rvalid.

Decomposition:
- Shared package holds:
  - ADDR_W / DATA_W constants.
  - State enum {ARB, INIT}.
  - Owner enum {OWN_A, OWN_B} for the pointer and read-return tag.
- One natural sub-module: rr_arbiter2, a 2-way round-robin grant plus pointer register.
- The top-level holds the FSM, sweep counter, RAM mux and read-return pipeline.
- RAM32_4 is instantiated outside this block.

Test Plan:
1. Reset, then A writes addr 5 data 0xA; A reads addr 5 next cycle -> gnt_a in both cycles; rvalid_a one cycle after the read with dout_a = 0xA.
2. A and B both request every cycle for 4 cycles, pointer = A after reset -> grants alternate A, B, A, B; no cycle has both grants; ram_addr tracks the granted address.
3. A reads addr 3 at cycle n, B reads addr 7 at n+1 (previously written 0x3, 0x7) -> rvalid_a at n+1 with 0x3; rvalid_b at n+2 with 0x7; never both in one cycle.
4. Fill addrs 0..31 with 0xF, pulse init_start -> init_busy high exactly 32 cycles; ram_addr steps 0..31 with ram_write = 1 and ram_din = 0; subsequent reads of addrs 0, 17 and 31 return 0x0.
5. init_start asserted in the same cycle as an A read of addr 2 (holding 0x5), with B requesting during INIT -> A read granted and rvalid_a = 1 with 0x5 in the first INIT cycle; gnt_b stays 0 until INIT ends, then B is granted on the first ARB cycle.
6. Assert reset at sweep count 10 -> next cycle: init_busy = 0, state ARB, all outputs at reset values; addrs 0..9 read 0, addr 20 retains its prior value.
